// File: rtl/residual_out_serializer_pkg.sv
// Shared definitions for the residual output serializer.
// Provides the serializer state encoding and the constant functions that
// derive beats-per-pixel, frame size and counter widths from the top-level
// parameters.
package residual_out_serializer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  // Channel-group beats needed to emit one pixel.
  function automatic int unsigned calc_beats(input int unsigned ch_in,
                                             input int unsigned ch_out);
    return ch_in / ch_out;
  endfunction

  // Pixels per frame.
  function automatic int unsigned calc_frame(input int unsigned img_w,
                                             input int unsigned img_h);
    return img_w * img_h;
  endfunction

  // Counter width able to index n values; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/residual_pixel_fifo.sv
// Synchronous pixel FIFO.
// Ports: clk, rst_n (async active-low), push/wdata (write), pop/rdata
// (read; rdata shows the head entry), full, empty. A push while full is
// accepted only when a pop happens in the same cycle.
module residual_pixel_fifo #(
  parameter int unsigned WIDTH = 4096,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             wr_en;
  logic             rd_en;

  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/residual_out_serializer.sv
// Residual chain output serializer.
// Buffers wide one-pixel-per-beat words (Valid only) in a small FIFO and
// re-emits each pixel as CH_IN/CH_OUT channel-group beats over Valid/Ready,
// group 0 first. Overflow is a sticky drop flag.
// Ports: clk, rst (async active-low), Data_In/Valid_In (upstream pixel),
// Data_Out/Valid_Out/Ready_In (downstream beats), Last_Out (final beat of
// final pixel in a frame), Overflow.
// Build option: define RESIDUAL_SER_FRAME_LAST_EN to include the frame pixel
// counter and drive Last_Out; otherwise Last_Out is tied low.
module residual_out_serializer
  import residual_out_serializer_pkg::*;
#(
  parameter int unsigned DATA_WIDHT = 32,
  parameter int unsigned IMG_WIDHT  = 44,
  parameter int unsigned IMG_HEIGHT = 44,
  parameter int unsigned CH_IN      = 128,
  parameter int unsigned CH_OUT     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDHT*CH_IN-1:0]  Data_In,
  input  logic                         Valid_In,
  output logic [DATA_WIDHT*CH_OUT-1:0] Data_Out,
  output logic                         Valid_Out,
  input  logic                         Ready_In,
  output logic                         Last_Out,
  output logic                         Overflow
);

  localparam int unsigned PIX_W  = DATA_WIDHT * CH_IN;
  localparam int unsigned GRP_W  = DATA_WIDHT * CH_OUT;
  localparam int unsigned BEATS  = calc_beats(CH_IN, CH_OUT);
  localparam int unsigned BEAT_W = cnt_width(BEATS);
  localparam int unsigned FRAME  = calc_frame(IMG_WIDHT, IMG_HEIGHT);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

  ser_state_t         state;
  logic [PIX_W-1:0]   sr;
  logic [BEAT_W-1:0]  beat;
  logic [PIX_W-1:0]   fifo_head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               hs;
  logic               beat_shift;
  logic               beat_done;

  assign hs         = (state == SEND) && Ready_In;
  assign beat_shift = hs && (beat != BEAT_LAST);
  assign beat_done  = hs && (beat == BEAT_LAST);
  // Next pixel is taken when idle, or back-to-back on the final beat.
  assign pop        = !fifo_empty && ((state == IDLE) || beat_done);
  // A full FIFO still takes a pixel when a pop frees a slot this cycle.
  assign push       = Valid_In && (!fifo_full || pop);

  residual_pixel_fifo #(
    .WIDTH (PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (push),
    .wdata (Data_In),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign Valid_Out = (state == SEND);
  assign Data_Out  = sr[GRP_W-1:0];

  // Serializer FSM: load a pixel, shift one group per handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sr    <= '0;
      beat  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            sr    <= fifo_head;
            beat  <= '0;
            state <= SEND;
          end
        end
        SEND: begin
          if (beat_shift) begin
            sr   <= sr >> GRP_W;
            beat <= beat + BEAT_W'(1);
          end else if (beat_done) begin
            if (pop) begin
              sr   <= fifo_head;
              beat <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky drop flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   Overflow <= 1'b0;
    else if (Valid_In && !push) Overflow <= 1'b1;
  end

`ifdef RESIDUAL_SER_FRAME_LAST_EN
  localparam int unsigned PIX_CNT_W = cnt_width(FRAME);
  localparam logic [PIX_CNT_W-1:0] PIX_LAST = PIX_CNT_W'(FRAME - 1);

  logic [PIX_CNT_W-1:0] pix;
  logic [PIX_CNT_W-1:0] pix_nxt;
  logic [BEAT_W-1:0]    beat_nxt;
  logic                 valid_nxt;
  logic                 last_q;

  // Look-ahead of the FSM so Last_Out can be registered in step with it.
  assign pix_nxt   = beat_done ? ((pix == PIX_LAST) ? '0 : pix + PIX_CNT_W'(1)) : pix;
  assign beat_nxt  = pop ? '0 : (beat_shift ? beat + BEAT_W'(1) : beat);
  assign valid_nxt = pop || (Valid_Out && !beat_done);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix    <= '0;
      last_q <= 1'b0;
    end else begin
      pix    <= pix_nxt;
      last_q <= valid_nxt && (beat_nxt == BEAT_LAST) && (pix_nxt == PIX_LAST);
    end
  end

  assign Last_Out = last_q;
`else
  logic [31:0] unused_frame;
  assign unused_frame = 32'(FRAME);
  assign Last_Out     = 1'b0;
`endif

endmodule

// File: tb/tb_residual_out_serializer.sv
// Bench for residual_out_serializer with a 2x2 frame. A transaction-level
// model (pixel queue, current pixel, beat index, frame position) predicts
// Valid_Out, Data_Out, Last_Out and Overflow after every clock edge.
module tb_residual_out_serializer;

  localparam int unsigned DW    = 32;
  localparam int unsigned CI    = 128;
  localparam int unsigned CO    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned IW    = 2;
  localparam int unsigned IH    = 2;
  localparam int unsigned PW    = DW * CI;
  localparam int unsigned GW    = DW * CO;
  localparam int unsigned BEATS = CI / CO;
  localparam int unsigned FRAME = IW * IH;

  typedef logic [PW-1:0] pix_t;

  logic          clk = 1'b0;
  logic          rst;
  pix_t          Data_In;
  logic          Valid_In;
  logic [GW-1:0] Data_Out;
  logic          Valid_Out;
  logic          Ready_In;
  logic          Last_Out;
  logic          Overflow;

  always #5 clk = ~clk;

  residual_out_serializer #(
    .DATA_WIDHT (DW),
    .IMG_WIDHT  (IW),
    .IMG_HEIGHT (IH),
    .CH_IN      (CI),
    .CH_OUT     (CO),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .Data_In   (Data_In),
    .Valid_In  (Valid_In),
    .Data_Out  (Data_Out),
    .Valid_Out (Valid_Out),
    .Ready_In  (Ready_In),
    .Last_Out  (Last_Out),
    .Overflow  (Overflow)
  );

  // Reference model state.
  pix_t  mq[$];
  pix_t  cur;
  int    cur_beat;
  bit    busy;
  int    mpix;
  bit    movf;

  int    n_vec;
  int    n_err;
  int    hs_cnt;
  int    last_seen;
  string phase;

  function automatic pix_t rand_pix();
    pix_t p;
    for (int i = 0; i < int'(CI); i++) p[i*DW +: DW] = DW'($urandom);
    return p;
  endfunction

  function automatic pix_t ramp_pix();
    pix_t p;
    for (int i = 0; i < int'(CI); i++) p[i*DW +: DW] = DW'(i);
    return p;
  endfunction

  task automatic model_reset();
    mq.delete();
    cur      = '0;
    cur_beat = 0;
    busy     = 1'b0;
    mpix     = 0;
    movf     = 1'b0;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s/%s observed=%b expected=%b", phase, tag, obs, exp);
    end
  endtask

  task automatic chk_data(input string tag, input logic [GW-1:0] obs, input logic [GW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s/%s observed=%h expected=%h", phase, tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s/%s observed=%0d expected=%0d", phase, tag, obs, exp);
    end
  endtask

  // One clock: drive after the falling edge, advance the model at the
  // rising edge, compare 1 time unit later.
  task automatic step(input logic vin, input pix_t din, input logic rdy);
    bit   hs, done, pop, acc;
    logic exp_last;
    Valid_In = vin;
    Data_In  = din;
    Ready_In = rdy;
    #1;
    if ((Valid_Out === 1'b1) && rdy) hs_cnt++;
    @(posedge clk);
    hs   = busy && rdy;
    done = hs && (cur_beat == int'(BEATS) - 1);
    pop  = (!busy || done) && (mq.size() > 0);
    acc  = vin && ((mq.size() < int'(DEPTH)) || pop);
    if (vin && !acc) movf = 1'b1;
    if (hs && !done) cur_beat++;
    if (done) begin
      mpix = (mpix + 1) % int'(FRAME);
      busy = 1'b0;
    end
    if (pop) begin
      cur      = mq.pop_front();
      cur_beat = 0;
      busy     = 1'b1;
    end
    if (acc) mq.push_back(din);
`ifdef RESIDUAL_SER_FRAME_LAST_EN
    exp_last = busy && (cur_beat == int'(BEATS) - 1) && (mpix == int'(FRAME) - 1);
`else
    exp_last = 1'b0;
`endif
    #1;
    chk1("valid", Valid_Out, busy);
    if (busy) chk_data("data", Data_Out, cur[cur_beat*GW +: GW]);
    chk1("last", Last_Out, exp_last);
    chk1("overflow", Overflow, movf);
    if (Last_Out === 1'b1) last_seen++;
    @(negedge clk);
  endtask

  // Asynchronous reset asserted at the current time; outputs must clear at once.
  task automatic apply_reset();
    rst      = 1'b0;
    Valid_In = 1'b0;
    Ready_In = 1'b0;
    Data_In  = '0;
    #1;
    chk1("rst_valid", Valid_Out, 1'b0);
    chk_data("rst_data", Data_Out, '0);
    chk1("rst_last", Last_Out, 1'b0);
    chk1("rst_overflow", Overflow, 1'b0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    hs_cnt    = 0;
    last_seen = 0;
    rst       = 1'b0;
    Valid_In  = 1'b0;
    Ready_In  = 1'b0;
    Data_In   = '0;
    model_reset();
    @(negedge clk);

    phase = "reset";
    apply_reset();

    phase = "single_ramp";
    step(1'b1, ramp_pix(), 1'b1);
    repeat (20) step(1'b0, '0, 1'b1);

    phase = "ready_toggle";
    hs_cnt = 0;
    step(1'b1, rand_pix(), 1'b1);
    for (int i = 0; i < 40; i++) step(1'b0, '0, (i % 2) == 1);
    chk_int("handshakes", hs_cnt, int'(BEATS));

    phase = "burst4";
    for (int i = 0; i < 4; i++) step(1'b1, rand_pix(), 1'b1);
    repeat (70) step(1'b0, '0, 1'b1);
    chk1("burst_no_ovf", Overflow, 1'b0);

    phase = "overflow";
    apply_reset();
    for (int i = 0; i < 6; i++) step(1'b1, rand_pix(), 1'b0);
    chk1("ovf_set", Overflow, 1'b1);
    for (int i = 0; i < 3; i++) step(1'($urandom_range(0, 1)), rand_pix(), 1'b0);
    for (int i = 0; i < 250; i++) step(1'b0, '0, $urandom_range(0, 3) != 0);
    chk1("ovf_sticky", Overflow, 1'b1);

    phase = "full_pop_push";
    apply_reset();
    for (int i = 0; i < 5; i++) step(1'b1, rand_pix(), 1'b0);
    chk1("full_no_ovf", Overflow, 1'b0);
    repeat (BEATS - 1) step(1'b0, '0, 1'b1);
    step(1'b1, rand_pix(), 1'b1);
    chk1("coincident_no_ovf", Overflow, 1'b0);
    repeat (100) step(1'b0, '0, 1'b1);

    phase = "mid_reset";
    for (int i = 0; i < 3; i++) step(1'b1, rand_pix(), 1'b1);
    for (int i = 0; i < 20; i++) begin
      if (busy && cur_beat == 5) break;
      step(1'b0, '0, 1'b1);
    end
    chk_int("reached_beat5", cur_beat, 5);
    apply_reset();
    repeat (20) step(1'b0, '0, 1'b1);

    phase = "frame";
    last_seen = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, rand_pix(), 1'b1);
      repeat (BEATS - 1) step(1'b0, '0, 1'b1);
    end
    repeat (20) step(1'b0, '0, 1'b1);
`ifdef RESIDUAL_SER_FRAME_LAST_EN
    chk_int("last_count", last_seen, 2);
`else
    chk_int("last_count", last_seen, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
